// File: rtl/c_one_hot_capture.sv
// One-hot capture stage: each accepted request vector is filtered to zero or one set bit,
// binary-encoded and queued in a 2-entry FIFO, and non-one-hot vectors are counted.
module c_one_hot_capture #(
    parameter int width       = 5,
    parameter int count_width = 8,
    localparam int idx_width  = $clog2(width)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [0:width-1]       data_in,
    input  logic                   valid_in,
    output logic                   ready_out,
    output logic [0:width-1]       data_out,
    output logic [0:idx_width-1]   index_out,
    output logic                   zero_out,
    output logic                   valid_out,
    input  logic                   ready_in,
    input  logic                   clear_count,
    output logic [0:count_width-1] violation_count
);

    function automatic logic is_multi(input logic [0:width-1] v);
        int n;
        n = 0;
        for (int i = 0; i < width; i++) begin
            if (v[i]) n++;
        end
        return (n > 1);
    endfunction

    function automatic logic [0:idx_width-1] encode(input logic [0:width-1] v);
        logic [0:idx_width-1] idx;
        idx = '0;
        for (int i = 0; i < width; i++) begin
            if (v[i]) idx = idx_width'(i);
        end
        return idx;
    endfunction

    function automatic logic [0:count_width-1] sat_inc(input logic [0:count_width-1] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    logic                   push, pop;
    logic                   multi_p0, viol_p0, zero_p0;
    logic [0:width-1]       data_p0;
    logic [0:idx_width-1]   idx_p0;

    logic [1:0]             occ_p1;
    logic                   wr_ptr_p1, rd_ptr_p1;
    logic [0:width-1]       data_mem_p1 [2];
    logic [0:idx_width-1]   idx_mem_p1  [2];
    logic                   zero_mem_p1 [2];
    logic [0:count_width-1] count_p1;

    // Stage p0: filter and encode the incoming vector
    assign push      = valid_in & ready_out;
    assign pop       = valid_out & ready_in;
    assign multi_p0  = is_multi(data_in);
    assign viol_p0   = push & multi_p0;
    assign data_p0   = multi_p0 ? '0 : data_in;
    assign idx_p0    = encode(data_p0);
    assign zero_p0   = ~|data_p0;

    // Stage p1: FIFO control and violation counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ_p1    <= 2'd0;
            wr_ptr_p1 <= 1'b0;
            rd_ptr_p1 <= 1'b0;
            count_p1  <= '0;
        end else begin
            case ({push, pop})
                2'b10:   occ_p1 <= occ_p1 + 2'd1;
                2'b01:   occ_p1 <= occ_p1 - 2'd1;
                default: occ_p1 <= occ_p1;
            endcase
            if (push) wr_ptr_p1 <= ~wr_ptr_p1;
            if (pop)  rd_ptr_p1 <= ~rd_ptr_p1;
            if (clear_count)  count_p1 <= viol_p0 ? count_width'(1) : '0;
            else if (viol_p0) count_p1 <= sat_inc(count_p1);
        end
    end

    // Entry storage needs no reset; outputs are masked until an entry is valid
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem_p1[wr_ptr_p1] <= data_p0;
            idx_mem_p1[wr_ptr_p1]  <= idx_p0;
            zero_mem_p1[wr_ptr_p1] <= zero_p0;
        end
    end

    assign ready_out       = (occ_p1 != 2'd2);
    assign valid_out       = (occ_p1 != 2'd0);
    assign data_out        = valid_out ? data_mem_p1[rd_ptr_p1] : '0;
    assign index_out       = valid_out ? idx_mem_p1[rd_ptr_p1]  : '0;
    assign zero_out        = valid_out ? zero_mem_p1[rd_ptr_p1] : 1'b0;
    assign violation_count = count_p1;

endmodule

// File: tb/tb_c_one_hot_capture.sv
// Scoreboard bench for c_one_hot_capture: a default instance plus a count_width=2 instance
// sharing the same stimulus, checked against an independent reference model.
module tb_c_one_hot_capture;

    logic       clk = 1'b0;
    logic       reset;
    logic [0:4] data_in;
    logic       valid_in, ready_in, clear_count;
    logic       ready_out, zero_out, valid_out;
    logic [0:4] data_out;
    logic [0:2] index_out;
    logic [0:7] violation_count;
    logic       ready_out2, zero_out2, valid_out2;
    logic [0:4] data_out2;
    logic [0:2] index_out2;
    logic [0:1] violation_count2;

    typedef struct {
        logic [0:4] d;
        int         idx;
        logic       z;
    } exp_t;

    exp_t q[$];
    int   ref_cnt, ref_cnt2;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    c_one_hot_capture #(.width(5), .count_width(8)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready_out), .data_out(data_out), .index_out(index_out),
        .zero_out(zero_out), .valid_out(valid_out), .ready_in(ready_in),
        .clear_count(clear_count), .violation_count(violation_count)
    );

    c_one_hot_capture #(.width(5), .count_width(2)) dut2 (
        .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready_out2), .data_out(data_out2), .index_out(index_out2),
        .zero_out(zero_out2), .valid_out(valid_out2), .ready_in(ready_in),
        .clear_count(clear_count), .violation_count(violation_count2)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [0:4] v);
        exp_t e;
        int   n;
        n = 0;
        for (int i = 0; i < 5; i++) if (v[i]) n++;
        e.d   = (n > 1) ? 5'b00000 : v;
        e.idx = 0;
        for (int i = 0; i < 5; i++) if (e.d[i]) e.idx = i;
        e.z   = (e.d == 5'b00000);
        return e;
    endfunction

    // One clock cycle: drive, check against the model, predict the effect of the edge
    task automatic step(input logic [0:4] d, input logic v, input logic r, input logic clr);
        exp_t e, h;
        logic push_ok, viol;
        data_in = d; valid_in = v; ready_in = r; clear_count = clr;
        #1;
        chk("ready_out", 32'(ready_out), 32'(q.size() < 2));
        chk("valid_out", 32'(valid_out), 32'(q.size() != 0));
        chk("count", 32'(violation_count), 32'(ref_cnt));
        chk("count2", 32'(violation_count2), 32'(ref_cnt2));
        if (q.size() == 0) begin
            chk("idle_data", 32'(data_out), 32'd0);
            chk("idle_zero", 32'(zero_out), 32'd0);
        end
        e = model(d);
        push_ok = v && (q.size() < 2);
        viol = push_ok && (e.d == 5'b00000) && (d != 5'b00000);
        if (r && q.size() != 0) begin
            h = q.pop_front();
            chk("data_out", 32'(data_out), 32'(h.d));
            chk("index_out", 32'(index_out), 32'(h.idx));
            chk("zero_out", 32'(zero_out), 32'(h.z));
        end
        if (push_ok) q.push_back(e);
        if (clr) begin
            ref_cnt  = viol ? 1 : 0;
            ref_cnt2 = viol ? 1 : 0;
        end else if (viol) begin
            if (ref_cnt < 255) ref_cnt++;
            if (ref_cnt2 < 3) ref_cnt2++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        q.delete();
        ref_cnt = 0;
        ref_cnt2 = 0;
        #2 reset = 1'b1;
    endtask

    initial begin
        int exp_sat[4];
        exp_sat = '{1, 2, 3, 3};
        reset = 1'b0; data_in = '0; valid_in = 0; ready_in = 0; clear_count = 0;
        ref_cnt = 0; ref_cnt2 = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_ready", 32'(ready_out), 32'd1);
        chk("rst_count", 32'(violation_count), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_index", 32'(index_out), 32'd0);
        chk("rst_zero", 32'(zero_out), 32'd0);
        reset = 1'b1;

        // Single push, visible the cycle after
        step(5'b00100, 1, 1, 0);
        chk("first_data", 32'(data_out), 32'(5'b00100));
        chk("first_index", 32'(index_out), 32'd2);
        chk("first_valid", 32'(valid_out), 32'd1);
        step(5'b00000, 0, 1, 0);

        // Back-to-back sweep of every 5-bit vector
        for (int i = 0; i < 32; i++) step(5'(i), 1, 1, 0);
        repeat (3) step(5'b00000, 0, 1, 0);
        chk("sweep_count", 32'(violation_count), 32'd26);

        // Fill with the head stalled, then offer a third vector while popping
        step(5'b10000, 1, 0, 0);
        step(5'b01000, 1, 0, 0);
        chk("full_ready", 32'(ready_out), 32'd0);
        step(5'b00010, 1, 1, 0);
        repeat (3) step(5'b00000, 0, 1, 0);

        // Saturation on the narrow counter, then clear combined with a violation
        pulse_reset();
        for (int k = 0; k < 4; k++) begin
            step(5'b11000, 1, 1, 0);
            chk("sat_count2", 32'(violation_count2), 32'(exp_sat[k]));
        end
        step(5'b00110, 1, 1, 1);
        chk("clr_viol2", 32'(violation_count2), 32'd1);
        chk("clr_viol", 32'(violation_count), 32'd1);
        step(5'b00000, 0, 1, 1);
        chk("clr_alone", 32'(violation_count), 32'd0);
        repeat (2) step(5'b00000, 0, 1, 0);

        // Steady push/pop at occupancy 1, then asynchronous reset mid-stream
        step(5'b00001, 1, 0, 0);
        for (int k = 0; k < 10; k++) begin
            step(5'(5'b10000 >> (k % 5)), 1, 1, 0);
            chk("occ1_valid", 32'(valid_out), 32'd1);
            chk("occ1_ready", 32'(ready_out), 32'd1);
        end
        step(5'b10100, 1, 1, 0);
        reset = 1'b0;
        #1;
        chk("async_valid", 32'(valid_out), 32'd0);
        chk("async_count", 32'(violation_count), 32'd0);
        chk("async_ready", 32'(ready_out), 32'd1);
        q.delete();
        ref_cnt = 0;
        ref_cnt2 = 0;
        #2 reset = 1'b1;
        step(5'b00001, 1, 1, 0);
        chk("post_rst_valid", 32'(valid_out), 32'd1);
        chk("post_rst_index", 32'(index_out), 32'd4);
        repeat (2) step(5'b00000, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
